// File: rtl/mica2_pkg.sv
// mica2_pkg
//   Shared definitions for the Mica2 sequencer slice.
//   - Opcode constants driven onto the program counter's opc input.
//   - Instruction field positions for the 8-bit instruction word:
//       [7:5] opcode, [4] ALU-use bit, [3:0] target address.
//   - Sequencer state encoding (enum), reused as plain 3-bit constants by
//     the FSM and by anything that inspects the debug state output.
package mica2_pkg;

  localparam int AW_DEF = 4;
  localparam int IW_DEF = 8;

  // Program counter opcodes.
  localparam logic [2:0] OP_INC  = 3'b000;
  localparam logic [2:0] OP_INCN = 3'b001;
  localparam logic [2:0] OP_JMP  = 3'b010;
  localparam logic [2:0] OP_JMPN = 3'b011;
  localparam logic [2:0] OP_BR   = 3'b100;
  localparam logic [2:0] OP_HOLD = 3'b111;

  // Instruction field positions.
  localparam int OPC_MSB = 7;
  localparam int OPC_LSB = 5;
  localparam int ALU_BIT = 4;
  localparam int DIR_LSB = 0;

  // Sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_UPDATE = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

endpackage

// File: rtl/mica2_decode.sv
// mica2_decode
//   Purely combinational field decoder for the instruction register.
//   Ports:
//     ir       in  IW  instruction register contents
//     is_halt  out 1   opcode is OP_HOLD (the HALT instruction)
//     uses_alu out 1   instruction needs an ALU operation first
//     opc      out 3   opcode to present to the program counter
//     dir      out AW  target address for jumps/branches
module mica2_decode
  import mica2_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int IW = IW_DEF
) (
  input  logic [IW-1:0] ir,
  output logic          is_halt,
  output logic          uses_alu,
  output logic [2:0]    opc,
  output logic [AW-1:0] dir
);

  always_comb begin
    opc      = ir[OPC_MSB:OPC_LSB];
    uses_alu = ir[ALU_BIT];
    dir      = ir[DIR_LSB +: AW];
    // HALT shares the encoding of "hold the PC"; it is never issued as an
    // update, it stops the sequencer instead.
    is_halt  = (ir[OPC_MSB:OPC_LSB] == OP_HOLD);
  end

endmodule

// File: rtl/secuenciador.sv
// secuenciador
//   Fetch/decode/execute sequencer for the Mica2 core. Fetches an
//   instruction from ROM (req/ack), optionally runs a handshaked ALU
//   operation, then drives the program counter controls for exactly one
//   cycle (UPDATE). All outputs are decoded from registered state only.
//
//   Handshakes: rom_req is held high for the whole FETCH state and the word
//   on rom_data is taken in the first cycle where rom_ack=1; alu_go is a
//   single-cycle pulse in the first EXEC cycle and the ALU result is taken in
//   the first EXEC cycle where alu_done=1 (including the alu_go cycle).
//   rom_ack outside FETCH and alu_done outside EXEC have no effect.
//
//   Ports:
//     ck        in  1   clock, rising edge
//     rst       in  1   asynchronous active-high reset
//     run       in  1   allows new instructions (sampled in IDLE/UPDATE)
//     rom_req   out 1   fetch request
//     rom_ack   in  1   ROM data valid
//     rom_data  in  IW  instruction word
//     alu_go    out 1   ALU start pulse
//     alu_done  in  1   ALU completion
//     alu_flag  in  1   ALU condition, captured on alu_done
//     pc_opc    out 3   program counter opcode
//     pc_x      out 1   program counter condition input
//     pc_dir    out AW  program counter target address
//     ir        out IW  instruction register
//     busy      out 1   not IDLE and not HALT
//     halted    out 1   in HALT
//     dbg_state out 3   current FSM state (mica2_pkg::state_e encoding)
module secuenciador
  import mica2_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int IW = IW_DEF
) (
  input  logic          ck,
  input  logic          rst,
  input  logic          run,
  output logic          rom_req,
  input  logic          rom_ack,
  input  logic [IW-1:0] rom_data,
  output logic          alu_go,
  input  logic          alu_done,
  input  logic          alu_flag,
  output logic [2:0]    pc_opc,
  output logic          pc_x,
  output logic [AW-1:0] pc_dir,
  output logic [IW-1:0] ir,
  output logic          busy,
  output logic          halted,
  output logic [2:0]    dbg_state
);

  localparam logic [2:0] S_IDLE   = ST_IDLE;
  localparam logic [2:0] S_FETCH  = ST_FETCH;
  localparam logic [2:0] S_DECODE = ST_DECODE;
  localparam logic [2:0] S_EXEC   = ST_EXEC;
  localparam logic [2:0] S_UPDATE = ST_UPDATE;
  localparam logic [2:0] S_HALT   = ST_HALT;

  logic [2:0]    state_q, state_d;
  logic [IW-1:0] ir_q, ir_d;
  logic          flag_q, flag_d;
  // Marks the first EXEC cycle so alu_go is a single pulse even when the
  // ALU takes several cycles to answer.
  logic          go_q, go_d;

  logic          dec_halt;
  logic          dec_alu;
  logic [2:0]    dec_opc;
  logic [AW-1:0] dec_dir;

  mica2_decode #(
    .AW (AW),
    .IW (IW)
  ) u_decode (
    .ir       (ir_q),
    .is_halt  (dec_halt),
    .uses_alu (dec_alu),
    .opc      (dec_opc),
    .dir      (dec_dir)
  );

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    flag_d  = flag_q;
    go_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (rom_ack) begin
          ir_d    = rom_data;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (dec_halt) begin
          state_d = S_HALT;
        end else if (dec_alu) begin
          state_d = S_EXEC;
          go_d    = 1'b1;
        end else begin
          state_d = S_UPDATE;
        end
      end
      S_EXEC: begin
        if (alu_done) begin
          flag_d  = alu_flag;
          state_d = S_UPDATE;
        end
      end
      S_UPDATE: begin
        state_d = run ? S_FETCH : S_IDLE;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      flag_q  <= 1'b0;
      go_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      flag_q  <= flag_d;
      go_q    <= go_d;
    end
  end

  // Moore outputs. Outside UPDATE the PC is told to hold, so the PC moves
  // only at the edge that ends UPDATE.
  always_comb begin
    rom_req   = (state_q == S_FETCH);
    alu_go    = (state_q == S_EXEC) && go_q;
    pc_opc    = OP_HOLD;
    pc_x      = 1'b0;
    pc_dir    = '0;
    if (state_q == S_UPDATE) begin
      pc_opc = dec_opc;
      pc_x   = flag_q;
      pc_dir = dec_dir;
    end
    ir        = ir_q;
    busy      = (state_q != S_IDLE) && (state_q != S_HALT);
    halted    = (state_q == S_HALT);
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_secuenciador.sv
module tb_secuenciador;
  import mica2_pkg::*;

  localparam int AW = 4;
  localparam int IW = 8;

  // ---------------- clock / reset ----------------
  logic ck = 1'b0;
  logic rst = 1'b1;
  always #5 ck = ~ck;

  logic          run = 1'b0;
  logic          rom_ack = 1'b0;
  logic [IW-1:0] rom_data = '0;
  logic          alu_done = 1'b0;
  logic          alu_flag = 1'b0;
  logic          rom_req, alu_go, pc_x, busy, halted;
  logic [2:0]    pc_opc, dbg_state;
  logic [AW-1:0] pc_dir;
  logic [IW-1:0] ir;

  secuenciador #(.AW(AW), .IW(IW)) dut (
    .ck        (ck),
    .rst       (rst),
    .run       (run),
    .rom_req   (rom_req),
    .rom_ack   (rom_ack),
    .rom_data  (rom_data),
    .alu_go    (alu_go),
    .alu_done  (alu_done),
    .alu_flag  (alu_flag),
    .pc_opc    (pc_opc),
    .pc_x      (pc_x),
    .pc_dir    (pc_dir),
    .ir        (ir),
    .busy      (busy),
    .halted    (halted),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];     // {opc, x, dir} expected per UPDATE
  int upd_cnt = 0;
  int go_cnt = 0;
  logic [3:0] pc_m = 4'd0;  // program counter model, fed by DUT outputs
  logic flag_m = 1'b0;
  logic [IW-1:0] ir_m = '0;
  logic [7:0] mon_e;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] want);
    checks++;
    if (obs !== want) begin
      failures++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, want, $time);
    end
  endtask

  // Output monitor: any non-hold opcode is an UPDATE cycle.
  always @(negedge ck) begin
    if (!rst) begin
      if (alu_go) go_cnt++;
      if (pc_opc != OP_HOLD) begin
        upd_cnt++;
        if (exp_q.size() == 0) begin
          chk("update_without_expect", 16'(exp_q.size()), 16'd1);
        end else begin
          mon_e = exp_q.pop_front();
          chk("update_triple", {8'd0, pc_opc, pc_x, pc_dir}, {8'd0, mon_e});
        end
        case ({pc_opc, pc_x})
          4'b0001, 4'b0010, 4'b1000: pc_m <= pc_m + 4'd1;
          4'b0101, 4'b0110, 4'b1001: pc_m <= pc_dir;
          default: pc_m <= pc_m;
        endcase
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge ck);
    #2;
  endtask

  // Called with the DUT in FETCH. Runs one instruction to completion.
  task automatic do_instr(input logic [7:0] data, input int ack_wait, input int done_wait,
                          input logic flag_v, input logic run_after);
    int u0;
    int g0;
    logic [2:0] op;
    u0 = upd_cnt;
    g0 = go_cnt;
    op = data[7:5];
    chk("fetch_req", rom_req, 1);
    chk("fetch_busy", busy, 1);
    rom_data = data;
    rom_ack = 1'b0;
    for (int i = 0; i < ack_wait; i++) begin
      step();
      chk("fetch_wait_req", rom_req, 1);
      chk("fetch_wait_ir", ir, ir_m);
    end
    rom_ack = 1'b1;
    step();
    rom_ack = 1'b0;
    rom_data = 8'($urandom);
    ir_m = data;
    chk("decode_ir", ir, data);
    chk("decode_req", rom_req, 0);
    chk("decode_opc_hold", pc_opc, OP_HOLD);
    if (op == OP_HOLD) begin
      run = 1'b1;
      step();
      chk("halt_halted", halted, 1);
      chk("halt_busy", busy, 0);
      for (int i = 0; i < 3; i++) begin
        step();
        chk("halt_req", rom_req, 0);
        chk("halt_stays", halted, 1);
      end
      chk("halt_no_update", 16'(upd_cnt - u0), 0);
      return;
    end
    run = run_after;
    if (data[4]) begin
      step();
      chk("exec_alu_go", alu_go, 1);
      chk("exec_busy", busy, 1);
      alu_flag = ~flag_v;
      rom_ack = 1'b1;  // stray ack outside FETCH
      for (int k = 0; k < done_wait; k++) begin
        step();
        chk("exec_go_once", alu_go, 0);
        chk("exec_opc_hold", pc_opc, OP_HOLD);
      end
      rom_ack = 1'b0;
      alu_done = 1'b1;
      alu_flag = flag_v;
      flag_m = flag_v;
    end
    exp_q.push_back({op, flag_m, data[3:0]});
    step();  // now in UPDATE
    alu_done = 1'b0;
    alu_flag = ~flag_v;
    step();
    chk("one_update", 16'(upd_cnt - u0), 1);
    chk("go_pulses", 16'(go_cnt - g0), {15'd0, data[4]});
    chk("after_req", rom_req, run_after);
    chk("after_busy", busy, run_after);
    chk("after_opc_hold", pc_opc, OP_HOLD);
    chk("after_ir", ir, data);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #12;
    chk("rst_req", rom_req, 0);
    chk("rst_go", alu_go, 0);
    chk("rst_opc", pc_opc, OP_HOLD);
    chk("rst_x", pc_x, 0);
    chk("rst_dir", pc_dir, 0);
    chk("rst_ir", ir, 0);
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    rst = 1'b0;
    step();
    chk("idle_no_run", busy, 0);
    run = 1'b1;
    step();

    do_instr(8'h00, 0, 0, 1'b0, 1'b1);
    chk("pc_after_00", pc_m, 4'd0);
    do_instr(8'h55, 0, 2, 1'b1, 1'b1);
    chk("pc_after_55", pc_m, 4'd5);
    do_instr(8'h83, 4, 0, 1'b0, 1'b1);
    chk("pc_after_83", pc_m, 4'd3);
    do_instr(8'h9A, 1, 0, 1'b0, 1'b1);
    chk("pc_after_9a", pc_m, 4'd4);
    do_instr(8'h67, 0, 0, 1'b0, 1'b0);
    chk("pc_after_67", pc_m, 4'd7);
    step();
    chk("idle_stays", busy, 0);

    // run dropped while the ALU is working
    run = 1'b1;
    step();
    do_instr(8'hB2, 0, 1, 1'b1, 1'b0);
    chk("pc_after_b2", pc_m, 4'd7);

    run = 1'b1;
    step();
    for (int n = 0; n < 10; n++) begin
      logic [7:0] d;
      d = {3'($urandom_range(0, 6)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15))};
      do_instr(d, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b1);
    end

    do_instr(8'hE0, 0, 0, 1'b0, 1'b1);
    rst = 1'b1;
    ir_m = '0;
    flag_m = 1'b0;
    #1;
    chk("halt_rst_halted", halted, 0);
    chk("halt_rst_busy", busy, 0);
    chk("halt_rst_ir", ir, 0);
    run = 1'b0;
    #2;
    rst = 1'b0;
    step();
    chk("post_halt_idle", busy, 0);

    // reset in the middle of a fetch
    run = 1'b1;
    step();
    rom_data = 8'h55;
    step();
    chk("midfetch_req", rom_req, 1);
    #1;
    rst = 1'b1;
    #1;
    chk("midfetch_rst_req", rom_req, 0);
    chk("midfetch_rst_busy", busy, 0);
    chk("midfetch_rst_opc", pc_opc, OP_HOLD);
    chk("midfetch_rst_ir", ir, 0);
    run = 1'b0;
    rom_ack = 1'b1;
    #1;
    rst = 1'b0;
    step();
    step();
    chk("late_ack_busy", busy, 0);
    chk("late_ack_ir", ir, 0);
    chk("late_ack_req", rom_req, 0);
    rom_ack = 1'b0;

    chk("queue_drained", 16'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/secuenciador.md
# secuenciador

Fetch/decode/execute sequencer for the Mica2 core. It fetches 8-bit instructions from program ROM with a req/ack handshake and optionally runs a handshaked ALU operation. It then drives the program counter's `opc`/`x`/`dir` inputs for exactly one cycle per instruction, so the PC advances, jumps or branches once per instruction. It sits between the ROM, the ALU and the 4-bit program counter, and it is the only source of PC control.

## Interface
- `AW`, 4: PC/address width; must match the program counter (4).
- `IW`, 8: instruction width; format `[7:5]` opcode, `[4]` ALU-use bit, `[3:0]` target address.
- `ck`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `run`  in  1  level; 1 allows new instructions to start.
- `rom_req`  out  1  fetch request; held until `rom_ack`.
- `rom_ack`  in  1  ROM data valid; sampled only while `rom_req`=1.
- `rom_data`  in  IW  instruction word, captured on `rom_ack`.
- `alu_go`  out  1  one-cycle start pulse to the ALU.
- `alu_done`  in  1  ALU completion; sampled only in EXEC.
- `alu_flag`  in  1  ALU condition, captured on `alu_done`.
- `pc_opc`  out  3  to PC `opc`.
- `pc_x`  out  1  to PC `x`.
- `pc_dir`  out  AW  to PC `dir`.
- `ir`  out  IW  current instruction register.
- `busy`  out  1  1 in any state except IDLE and HALT.
- `halted`  out  1  1 in HALT.

## Operation
- Opcode 3'b111 (`OP_HOLD`) leaves the PC unchanged.
  - `pc_opc`=`OP_HOLD` in every state except UPDATE.
  - An instruction with opcode 3'b111 is HALT.
- PC update semantics (`opc`/`x`):
  - 000/1 → +1; 000/0 → hold
  - 001/0 → +1
  - 010/1 → jump
  - 011/0 → jump
  - 100/1 → jump; 100/0 → +1
  - all other combinations → hold
- `flag` register: reset 0.
  - Loaded from `alu_flag` only on `alu_done` in EXEC.
  - Non-ALU instructions reuse the retained value.
- States:
  - IDLE → FETCH when `run`=1.
  - FETCH: `rom_req`=1. On `rom_ack`, `ir`←`rom_data` and go to DECODE.
  - DECODE:
    - opcode 111 → HALT.
    - else `ir[4]`=1 → EXEC, with `alu_go`=1 for the first EXEC cycle only.
    - else → UPDATE.
  - EXEC: wait for `alu_done`, then `flag`←`alu_flag` and go to UPDATE.
  - UPDATE: `pc_opc`=`ir[7:5]`, `pc_x`=`flag`, `pc_dir`=`ir[3:0]` for one cycle. Then → FETCH if `run`=1, else → IDLE.
  - HALT: terminal; exits only via `rst`.
- Reset values:
  - state IDLE
  - `ir`=0, `flag`=0
  - `rom_req`=0, `alu_go`=0
  - `pc_opc`=3'b111, `pc_x`=0, `pc_dir`=0
  - `busy`=0, `halted`=0
- The PC itself has no reset and is not touched by this block.

## Timing
- All outputs are Moore, decoded from registered state and registers; no combinational input-to-output path.
- The PC changes at the rising edge that ends UPDATE.
- Non-ALU instruction with same-cycle ack: 3 cycles (FETCH, DECODE, UPDATE).
- ALU instruction: 3 + (cycles spent in EXEC), where EXEC is at least 1 cycle.
- ROM wait: each cycle without `rom_ack` adds one FETCH cycle; `rom_req` stays high with no gap.
- `alu_done` in the same cycle as `alu_go`: accepted; EXEC lasts 1 cycle.
- `run` is sampled only in IDLE and UPDATE. Deasserting it mid-instruction completes the current instruction, then the block goes to IDLE.
- `rom_ack` outside FETCH and `alu_done` outside EXEC are ignored.
- `rst` during any state:
  - immediate return to IDLE with reset values
  - `rom_req` drops asynchronously
  - a partially fetched or executed instruction is discarded

## Structure
- Shared package `mica2_pkg` holds:
  - opcode constants `OP_INC`=000, `OP_INCN`=001, `OP_JMP`=010, `OP_JMPN`=011, `OP_BR`=100, `OP_HOLD`=111
  - instruction field positions
  - state enum (IDLE, FETCH, DECODE, EXEC, UPDATE, HALT)
- One natural sub-module: `mica2_decode`, combinational from `ir` to {is_halt, uses_alu, opc, dir}. The FSM stays in `secuenciador`.

## Test plan
- Reset, then `run`=1, `rom_data`=8'h00 with immediate ack → `pc_opc`=000 and `pc_x`=0 only in UPDATE (cycle 3); next FETCH begins in cycle 4.
- `rom_data`=8'h55 (op 010, ALU, dir 5); `alu_done` 2 cycles after `alu_go`, `alu_flag`=1 → single `alu_go` pulse; UPDATE shows `pc_opc`=010, `pc_x`=1, `pc_dir`=5; PC becomes 5.
- `rom_ack` delayed 4 cycles → `rom_req` high for 5 consecutive cycles; `ir` unchanged until ack.
- `rom_data`=8'hE0 → HALT: `halted`=1, `busy`=0, `rom_req` stays 0 while `run`=1; `rst` pulse → IDLE.
- Deassert `run` during EXEC → instruction finishes, one UPDATE occurs, then IDLE with `pc_opc`=111.
- Assert `rst` mid-FETCH → `rom_req` 0 in the same cycle, all outputs at reset values, a late `rom_ack` is ignored.
